// File: rtl/l1_thresh_pkg.sv
// Shared address map, control bit positions and apply FSM states for the L1 threshold block.
// No logic; constants and types only.
// No flow control; consumers decide how these are used.
package l1_thresh_pkg;

    localparam logic [12:0] THR_BASE = 13'h0800;
    localparam logic [12:0] CTRL     = 13'h1800;
    localparam logic [12:0] STAT     = 13'h1804;
    localparam logic [12:0] SCRATCH  = 13'h1808;

    localparam int CTRL_LOAD_DEFAULTS = 0;
    localparam int CTRL_APPLY         = 1;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } apply_state_t;

endpackage

// File: rtl/l1_thresh_streamer.sv
// Apply FSM: streams the shadow thresholds one beam per cycle, then pulses update and bumps the count.
// Latency: first update word one cycle after the apply is accepted, NBEAMS words, then one DONE cycle.
// No backpressure from the store; further apply requests while active collapse into one pending apply.
module l1_thresh_streamer
    import l1_thresh_pkg::*;
#(
    parameter int NBEAMS      = 48,
    parameter int THRESH_BITS = 18
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_n_i,
    input  logic                   apply_req,
    input  logic [THRESH_BITS-1:0] rd_thr,
    input  logic [THRESH_BITS-1:0] rd_subthr,
    output logic [5:0]             rd_beam,
    output logic                   idle,
    output logic                   busy,
    output logic                   pending,
    output logic [15:0]            apply_cnt,
    output logic                   thr_wr,
    output logic [5:0]             thr_beam,
    output logic [THRESH_BITS-1:0] thr,
    output logic [THRESH_BITS-1:0] subthr,
    output logic                   thr_update
);

    localparam logic [5:0] LAST_BEAM = 6'(NBEAMS - 1);

    apply_state_t state, state_nxt;
    logic [5:0]   beam, beam_nxt;
    logic         pending_nxt;

    always_comb begin
        state_nxt   = state;
        beam_nxt    = beam;
        pending_nxt = pending;
        case (state)
            IDLE: begin
                if (apply_req) begin
                    state_nxt = STREAM;
                    beam_nxt  = 6'd0;
                end
            end
            STREAM: begin
                if (apply_req) pending_nxt = 1'b1;
                if (beam == LAST_BEAM) begin
                    state_nxt = DONE;
                    beam_nxt  = 6'd0;
                end else begin
                    beam_nxt = beam + 6'd1;
                end
            end
            DONE: begin
                // A request landing in the DONE cycle itself counts as pending.
                if (pending || apply_req) begin
                    state_nxt   = STREAM;
                    beam_nxt    = 6'd0;
                    pending_nxt = 1'b0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state      <= IDLE;
            beam       <= 6'd0;
            pending    <= 1'b0;
            busy       <= 1'b0;
            apply_cnt  <= 16'd0;
            thr_wr     <= 1'b0;
            thr_beam   <= 6'd0;
            thr        <= '0;
            subthr     <= '0;
            thr_update <= 1'b0;
        end else begin
            state      <= state_nxt;
            beam       <= beam_nxt;
            pending    <= pending_nxt;
            busy       <= (state != IDLE);
            thr_wr     <= (state == STREAM);
            thr_update <= (state == DONE);
            if (state == STREAM) begin
                thr_beam <= beam;
                thr      <= rd_thr;
                subthr   <= rd_subthr;
            end
            if (state == DONE) apply_cnt <= apply_cnt + 16'd1;
        end
    end

    assign idle    = (state == IDLE);
    assign rd_beam = beam;

endmodule

// File: rtl/l1_thresh_wb_regs.sv
// Wishbone classic register map holding shadow beam thresholds and streaming them to the L1 store on APPLY.
// Latency: registered ack one cycle after cyc&stb (one wait state, never on consecutive cycles).
// Threshold-region and LOAD_DEFAULTS writes hold off ack while an apply is active; other accesses never stall.
module l1_thresh_wb_regs
    import l1_thresh_pkg::*;
#(
    parameter int                     NBEAMS         = 48,
    parameter int                     THRESH_BITS    = 18,
    parameter logic [THRESH_BITS-1:0] THRESH_DEFAULT = {THRESH_BITS{1'b1}}
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_n_i,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic                   wb_we_i,
    input  logic [12:0]            wb_adr_i,
    input  logic [3:0]             wb_sel_i,
    input  logic [31:0]            wb_dat_i,
    output logic [31:0]            wb_dat_o,
    output logic                   wb_ack_o,
    output logic                   thr_wr_o,
    output logic [5:0]             thr_beam_o,
    output logic [THRESH_BITS-1:0] thr_o,
    output logic [THRESH_BITS-1:0] subthr_o,
    output logic                   thr_update_o
);

    logic [THRESH_BITS-1:0] thr_sh [NBEAMS];
    logic [THRESH_BITS-1:0] sub_sh [NBEAMS];
    logic [31:0]            scratch;
    logic [31:0]            rdata;

    logic        idle, busy, pending;
    logic [15:0] apply_cnt;
    logic [5:0]  rd_beam;

    logic       req, full_sel, aligned, in_thr, beam_ok, a_sub;
    logic       is_ctrl, is_stat, is_scr;
    logic       stall, accept, wr, apply_req, load_def, thr_we;
    logic [5:0] a_beam;

    assign req      = wb_cyc_i && wb_stb_i && !wb_ack_o;
    assign full_sel = (wb_sel_i == 4'hF);
    assign aligned  = (wb_adr_i[1:0] == 2'b00);
    assign in_thr   = (wb_adr_i[12:11] == THR_BASE[12:11]);
    assign a_beam   = wb_adr_i[8:3];
    assign a_sub    = wb_adr_i[2];
    assign beam_ok  = in_thr && aligned && (wb_adr_i[10:9] == 2'b00)
                      && ({1'b0, a_beam} < 7'(NBEAMS));
    assign is_ctrl  = (wb_adr_i == CTRL);
    assign is_stat  = (wb_adr_i == STAT);
    assign is_scr   = (wb_adr_i == SCRATCH);

    // Shadow must not change under an in-flight stream, so those writes wait for IDLE.
    assign stall     = req && wb_we_i && !idle
                       && (in_thr || (is_ctrl && full_sel && wb_dat_i[CTRL_LOAD_DEFAULTS]));
    assign accept    = req && !stall;
    assign wr        = accept && wb_we_i && full_sel;
    assign apply_req = wr && is_ctrl && wb_dat_i[CTRL_APPLY];
    assign load_def  = wr && is_ctrl && wb_dat_i[CTRL_LOAD_DEFAULTS];
    assign thr_we    = wr && beam_ok;

    always_comb begin
        rdata = 32'd0;
        if (beam_ok)      rdata = a_sub ? 32'(sub_sh[a_beam]) : 32'(thr_sh[a_beam]);
        else if (is_stat) rdata = {apply_cnt, 14'd0, pending, busy};
        else if (is_scr)  rdata = scratch;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= 32'd0;
            scratch  <= 32'd0;
        end else begin
            wb_ack_o <= accept;
            wb_dat_o <= accept ? rdata : 32'd0;
            if (wr && is_scr) scratch <= wb_dat_i;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            for (int b = 0; b < NBEAMS; b++) begin
                thr_sh[b] <= THRESH_DEFAULT;
                sub_sh[b] <= THRESH_DEFAULT;
            end
        end else if (load_def) begin
            for (int b = 0; b < NBEAMS; b++) begin
                thr_sh[b] <= THRESH_DEFAULT;
                sub_sh[b] <= THRESH_DEFAULT;
            end
        end else if (thr_we) begin
            if (a_sub) sub_sh[a_beam] <= wb_dat_i[THRESH_BITS-1:0];
            else       thr_sh[a_beam] <= wb_dat_i[THRESH_BITS-1:0];
        end
    end

    l1_thresh_streamer #(
        .NBEAMS      (NBEAMS),
        .THRESH_BITS (THRESH_BITS)
    ) u_streamer (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_n_i (wb_rst_n_i),
        .apply_req  (apply_req),
        .rd_thr     (thr_sh[rd_beam]),
        .rd_subthr  (sub_sh[rd_beam]),
        .rd_beam    (rd_beam),
        .idle       (idle),
        .busy       (busy),
        .pending    (pending),
        .apply_cnt  (apply_cnt),
        .thr_wr     (thr_wr_o),
        .thr_beam   (thr_beam_o),
        .thr        (thr_o),
        .subthr     (subthr_o),
        .thr_update (thr_update_o)
    );

endmodule

// File: doc/l1_thresh_wb_regs.md
# l1_thresh_wb_regs

Wishbone classic responder (slave) that owns the L1 beam-threshold register map. It holds a shadow copy of per-beam threshold and sub-threshold values written by the Wishbone initiator. On command, it streams them, one beam per cycle, into the L1 trigger's active threshold store. It sits between the SURF Wishbone interconnect and the L1 trigger core, in the wb_clk_i domain.

## Interface
Parameters:
- NBEAMS, 48, number of beams; legal range 1..64.
- THRESH_BITS, 18, threshold width.
- THRESH_DEFAULT, 18'h3FFFF, reset value of every threshold and sub-threshold (no triggers).

Ports (clock and reset first):
- wb_clk_i  in  1  sole clock.
- wb_rst_n_i  in  1  asynchronous, active-low reset.
- wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone classic strobes.
- wb_adr_i  in  13  byte address.
- wb_sel_i  in  4  byte selects.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  acknowledge.
- thr_wr_o  out  1  one-cycle strobe; an update word is valid.
- thr_beam_o  out  6  beam index of the update word.
- thr_o, subthr_o  out  THRESH_BITS each  update values.
- thr_update_o  out  1  one-cycle pulse after the last beam of an apply.

## Operation
Address map:
- 0x0800 + 8·b: threshold, beam b (b < NBEAMS).
- 0x0804 + 8·b: sub-threshold, beam b (b < NBEAMS).
- 0x1800: control. Bit1 = APPLY (write 1 starts an apply; self-clearing; reads 0). Bit0 = LOAD_DEFAULTS (write 1 sets every shadow value to THRESH_DEFAULT in one cycle).
- 0x1804: status. Bit0 = busy. Bit1 = apply pending. Bits[31:16] = apply-complete count, wrapping at 16 bits.
- 0x1808: scratch register, 32-bit read/write.

Write rules:
- A write takes effect only when wb_sel_i == 4'hF. Any other select value is acked but ignored.
- Threshold writes keep bits [THRESH_BITS-1:0]. Upper bits read back 0.

Unmapped accesses (including beams ≥ NBEAMS): ack with read data 0; writes are dropped. No error/retry.

Apply FSM states:
- IDLE: APPLY written -> STREAM, beam = 0.
- STREAM: each cycle assert thr_wr_o with the shadow values of the current beam, then increment beam. After beam NBEAMS-1 -> DONE.
- DONE: pulse thr_update_o and increment the apply count. If pending is set, clear it and go to STREAM with beam = 0; otherwise go to IDLE.

Apply boundary cases:
- APPLY written while not IDLE sets pending. Multiple APPLY writes collapse into one pending apply.
- While not IDLE, writes to the threshold region (0x0800–0x0FFF) stall: ack is withheld until the FSM reaches IDLE. This keeps every streamed set coherent.
- Control, status and scratch accesses never stall.
- A LOAD_DEFAULTS write while not IDLE also stalls.

## Timing
- Ack: registered. It asserts the cycle after cyc&stb is seen (one wait state), for exactly one cycle, and never on two consecutive cycles. Back-to-back transfers therefore run at one per 2 cycles.
- wb_dat_o is valid in the ack cycle and is 0 when ack is low.
- APPLY: the write acked at cycle N gives the first thr_wr_o at N+1. The last thr_wr_o is at N+NBEAMS. thr_update_o is at N+NBEAMS+1. busy is set from N+1 through N+NBEAMS+1.
- A pending apply restarts streaming on the cycle after DONE. There is no idle gap besides the DONE cycle.
- Reset (asynchronous assert, synchronous deassert assumed upstream):
  - wb_ack_o=0, wb_dat_o=0, thr_wr_o=0, thr_update_o=0, thr_beam_o=0, thr_o=0, subthr_o=0.
  - FSM returns to IDLE; pending=0; count=0; scratch=0.
  - All shadow values return to THRESH_DEFAULT.
- Reset mid-stream aborts the apply with no thr_update_o. The downstream store keeps its partial contents.

## Structure
- Shared package l1_thresh_pkg:
  - Address constants: THR_BASE=13'h0800, CTRL=13'h1800, STAT=13'h1804, SCRATCH=13'h1808.
  - Control bit indices.
  - FSM state enum {IDLE, STREAM, DONE}.
- Shadow storage: NBEAMS×2×THRESH_BITS flops (not BRAM), because LOAD_DEFAULTS clears all values in one cycle.
- One sub-module, l1_thresh_streamer: the apply FSM, beam counter and pending flag. It has a read port into the shadow array.

## Test plan
1. Reset, then read 0x0800, 0x0804, 0x1804 and 0x1808 -> 0x3FFFF, 0x3FFFF, 0, 0. Each ack lasts one cycle.
2. Write 0x0800=5000, 0x0804=4000, 0x0808=5001, 0x080C=300, then write 0x1800=0x2 -> 48 thr_wr_o strobes. Beam 0 carries (5000,4000); beam 1 carries (5001,300); beams 2–47 carry 0x3FFFF. Then one thr_update_o pulse, and status bits[31:16]=1.
3. Write 0x1808=0x200, then read it -> 0x200. Write 0x1808 with sel=4'h3 -> value unchanged, ack still given.
4. Write APPLY twice, the second during streaming -> two full 48-beam streams separated only by the DONE cycle; count=2.
5. Write 0x0800 mid-stream -> ack delayed until IDLE. The new value appears only in the next apply.
6. Read 0x0A00 (beam 64, unmapped) -> 0 with ack. Assert reset at beam 20 of a stream -> outputs 0 immediately, no thr_update_o, shadow values back to 0x3FFFF.
